// File: rtl/sid_cfg_ctrl.sv
// sid_cfg_ctrl - run-time configurator for the two emulated SIDs.
// A command sequence is written through SID1 register $1F. It is unlocked with
// 52 44 50 and followed by any number of commands. Each command updates a
// shadow copy of the SID config. The shadow is copied to cfg1/cfg2 only while
// the voice and filter pipelines are idle, so the filter cfg mux never changes
// in the middle of a sample.
//
// Ports
//   clk        system clock
//   res        asynchronous active-high reset
//   tick_ms    one-clk pulse at ~1 kHz, drives the sequence timeout
//   wr         one-clk pulse per completed bus write
//   cs[1:0]    chip selects at the write (bit0 SID1, bit1 SID2)
//   addr[4:0]  SID register address of the write
//   data[7:0]  write data
//   pipe_idle  voice and filter pipelines both at cycle 0
//   cfg1/cfg2  applied configs: [23] model, [22:20] addr, [19:11] p9, [10:0] s11
//   cfg_upd    one-clk pulse in the first cycle that cfg1/cfg2 show new values
//   seq_open   command sequence in progress (state != IDLE)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | locked, waiting for 52
// K1    | 52 seen, waiting for 44
// K2    | 52 44 seen, waiting for 50
// CMD   | unlocked, next byte is a command (op = [7:6], tgt = [0])
// D0    | first data byte of the latched command
// D1    | second data byte of a p9/s11 command, low byte held in lsb_q

module sid_cfg_ctrl #(
  parameter logic [23:0] CFG1_DEFAULT = 24'h800000,
  parameter logic [23:0] CFG2_DEFAULT = 24'h800000,
  parameter int          TIMEOUT_MS   = 8
) (
  input  logic        clk,
  input  logic        res,
  input  logic        tick_ms,
  input  logic        wr,
  input  logic [1:0]  cs,
  input  logic [4:0]  addr,
  input  logic [7:0]  data,
  input  logic        pipe_idle,
  output logic [23:0] cfg1,
  output logic [23:0] cfg2,
  output logic        cfg_upd,
  output logic        seq_open
);

  localparam int            TW     = $clog2(TIMEOUT_MS + 1);
  localparam logic [TW-1:0] TO_CNT = TW'(TIMEOUT_MS);

  typedef enum logic [2:0] {
    S_IDLE, S_K1, S_K2, S_CMD, S_D0, S_D1
  } state_t;

  state_t        state_q;
  logic [1:0]    op_q;
  logic          tgt_q;
  logic [7:0]    lsb_q;
  logic [23:0]   sh1_q, sh2_q;
  logic          pending_q;
  logic [TW-1:0] tmo_q;

  logic acc, abort, timeout, apply;

  always_comb begin
    acc     = wr & cs[0] & (addr == 5'h1F);
    abort   = wr & (cs != 2'b00) & ~acc & (state_q != S_IDLE);
    timeout = (state_q != S_IDLE) & (tmo_q == TO_CNT);
    apply   = pending_q & pipe_idle;
  end

  assign seq_open = (state_q != S_IDLE);

  // The apply block runs first; a command completing on the same edge then
  // overrides pending_q back to 1, so the apply copies the old shadow and the
  // new value waits for the next idle window.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= S_IDLE;
      op_q      <= 2'b00;
      tgt_q     <= 1'b0;
      lsb_q     <= 8'h00;
      sh1_q     <= CFG1_DEFAULT;
      sh2_q     <= CFG2_DEFAULT;
      pending_q <= 1'b0;
      tmo_q     <= '0;
      cfg1      <= CFG1_DEFAULT;
      cfg2      <= CFG2_DEFAULT;
      cfg_upd   <= 1'b0;
    end else begin
      cfg_upd <= 1'b0;
      if (apply) begin
        cfg1      <= sh1_q;
        cfg2      <= sh2_q;
        pending_q <= 1'b0;
        cfg_upd   <= 1'b1;
      end

      // timeout counter saturates; cleared while locked and on every accepted write
      if (state_q == S_IDLE || acc)
        tmo_q <= '0;
      else if (tick_ms && tmo_q != TO_CNT)
        tmo_q <= tmo_q + TW'(1);

      if (timeout) begin
        state_q <= S_IDLE;
        lsb_q   <= 8'h00;
      end else if (abort) begin
        state_q <= S_IDLE;
      end else if (acc) begin
        case (state_q)
          S_IDLE: if (data == 8'h52) state_q <= S_K1;
          S_K1:   state_q <= (data == 8'h44) ? S_K2 : S_IDLE;
          S_K2:   state_q <= (data == 8'h50) ? S_CMD : S_IDLE;
          S_CMD: begin
            op_q    <= data[7:6];
            tgt_q   <= data[0];
            state_q <= S_D0;
          end
          S_D0: begin
            case (op_q)
              2'b00: begin
                if (tgt_q) sh2_q[23] <= data[0];
                else       sh1_q[23] <= data[0];
                pending_q <= 1'b1;
                state_q   <= S_CMD;
              end
              2'b01: begin
                // SID1 is fixed at D400; only SID2 may be relocated
                if (!tgt_q) begin
                  pending_q <= 1'b1;
                  state_q   <= S_CMD;
                end else if (data[7:3] != 5'b00000) begin
                  state_q <= S_IDLE;
                end else begin
                  sh2_q[22:20] <= data[2:0];
                  pending_q    <= 1'b1;
                  state_q      <= S_CMD;
                end
              end
              default: begin
                lsb_q   <= data;
                state_q <= S_D1;
              end
            endcase
          end
          S_D1: begin
            if (op_q == 2'b10) begin
              if (tgt_q) sh2_q[19:11] <= {data[0], lsb_q};
              else       sh1_q[19:11] <= {data[0], lsb_q};
            end else begin
              if (tgt_q) sh2_q[10:0] <= {data[2:0], lsb_q};
              else       sh1_q[10:0] <= {data[2:0], lsb_q};
            end
            pending_q <= 1'b1;
            state_q   <= S_CMD;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sid_cfg_ctrl.sv
// tb_sid_cfg_ctrl - directed self-checking bench for sid_cfg_ctrl.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_sid_cfg_ctrl;

  logic        clk = 1'b0;
  logic        res, tick_ms, wr, pipe_idle;
  logic [1:0]  cs;
  logic [4:0]  addr;
  logic [7:0]  data;
  logic [23:0] cfg1, cfg2;
  logic        cfg_upd, seq_open;

  int n_cmp = 0;
  int n_err = 0;

  sid_cfg_ctrl dut (
    .clk(clk), .res(res), .tick_ms(tick_ms), .wr(wr), .cs(cs), .addr(addr),
    .data(data), .pipe_idle(pipe_idle), .cfg1(cfg1), .cfg2(cfg2),
    .cfg_upd(cfg_upd), .seq_open(seq_open)
  );

  always #5 clk = ~clk;

  task automatic wr_reg(input logic [1:0] c, input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    wr = 1'b1; cs = c; addr = a; data = d;
    @(negedge clk);
    wr = 1'b0; cs = 2'b00; addr = 5'h00; data = 8'h00;
  endtask

  task automatic w1f(input logic [7:0] d);
    wr_reg(2'b01, 5'h1F, d);
  endtask

  task automatic unlock();
    w1f(8'h52); w1f(8'h44); w1f(8'h50);
  endtask

  task automatic tick();
    @(negedge clk); tick_ms = 1'b1;
    @(negedge clk); tick_ms = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    res = 1'b1; tick_ms = 1'b0; wr = 1'b0; cs = 2'b00; addr = 5'h00;
    data = 8'h00; pipe_idle = 1'b0;
    @(negedge clk);
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    if (cfg1 !== 24'h800000) begin $display("FAIL reset_cfg1: got %h want 800000", cfg1); n_err++; end
    n_cmp++;
    if (cfg2 !== 24'h800000) begin $display("FAIL reset_cfg2: got %h want 800000", cfg2); n_err++; end
    n_cmp++;
    if (cfg_upd !== 1'b0) begin $display("FAIL reset_upd: got %b want 0", cfg_upd); n_err++; end
    n_cmp++;
    if (seq_open !== 1'b0) begin $display("FAIL reset_open: got %b want 0", seq_open); n_err++; end
    n_cmp++;
  endtask

  task automatic test_model();
    do_reset();
    unlock();
    w1f(8'h01); w1f(8'h00);
    if (seq_open !== 1'b1) begin $display("FAIL model_open: got %b want 1", seq_open); n_err++; end
    n_cmp++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cfg_upd !== 1'b0 || cfg2 !== 24'h800000) begin
        $display("FAIL model_hold: upd %b cfg2 %h want 0 / 800000", cfg_upd, cfg2); n_err++;
      end
      n_cmp++;
    end
    pipe_idle = 1'b1;
    @(negedge clk);
    if (cfg2 !== 24'h000000) begin $display("FAIL model_cfg2: got %h want 000000", cfg2); n_err++; end
    n_cmp++;
    if (cfg_upd !== 1'b1) begin $display("FAIL model_upd: got %b want 1", cfg_upd); n_err++; end
    n_cmp++;
    if (cfg1 !== 24'h800000) begin $display("FAIL model_cfg1: got %h want 800000", cfg1); n_err++; end
    n_cmp++;
    @(negedge clk);
    if (cfg_upd !== 1'b0) begin $display("FAIL model_pulse: got %b want 0", cfg_upd); n_err++; end
    n_cmp++;
    pipe_idle = 1'b0;
  endtask

  task automatic test_p9_s11();
    int pulses;
    do_reset();
    unlock();
    w1f(8'h81); w1f(8'h34); w1f(8'h01);
    w1f(8'hC0); w1f(8'hFF); w1f(8'h07);
    if (cfg_upd !== 1'b0 || cfg1 !== 24'h800000) begin
      $display("FAIL ps_hold: upd %b cfg1 %h want 0 / 800000", cfg_upd, cfg1); n_err++;
    end
    n_cmp++;
    pipe_idle = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cfg_upd === 1'b1) pulses++;
    end
    pipe_idle = 1'b0;
    if (pulses != 1) begin $display("FAIL ps_pulses: got %0d want 1", pulses); n_err++; end
    n_cmp++;
    if (cfg2 !== 24'h89A000) begin $display("FAIL ps_cfg2: got %h want 89a000", cfg2); n_err++; end
    n_cmp++;
    if (cfg1 !== 24'h8007FF) begin $display("FAIL ps_cfg1: got %h want 8007ff", cfg1); n_err++; end
    n_cmp++;
  endtask

  task automatic test_abort();
    do_reset();
    unlock();
    if (seq_open !== 1'b1) begin $display("FAIL abort_open: got %b want 1", seq_open); n_err++; end
    n_cmp++;
    wr_reg(2'b01, 5'h00, 8'h12);
    if (seq_open !== 1'b0) begin $display("FAIL abort_addr: got %b want 0", seq_open); n_err++; end
    n_cmp++;
    w1f(8'h41);
    if (seq_open !== 1'b0) begin $display("FAIL abort_idle41: got %b want 0", seq_open); n_err++; end
    n_cmp++;
    w1f(8'h52);
    if (seq_open !== 1'b1) begin $display("FAIL abort_relock: got %b want 1", seq_open); n_err++; end
    n_cmp++;
    wr_reg(2'b10, 5'h1F, 8'h44);
    if (seq_open !== 1'b0) begin $display("FAIL abort_sid2: got %b want 0", seq_open); n_err++; end
    n_cmp++;
    // a write with no chip select does not disturb the sequence
    unlock();
    wr_reg(2'b00, 5'h03, 8'h00);
    if (seq_open !== 1'b1) begin $display("FAIL abort_nocs: got %b want 1", seq_open); n_err++; end
    n_cmp++;
  endtask

  task automatic test_addr();
    int pulses;
    do_reset();
    pipe_idle = 1'b1;
    unlock();
    w1f(8'h41); w1f(8'h08);
    if (seq_open !== 1'b0) begin $display("FAIL addr_rej_open: got %b want 0", seq_open); n_err++; end
    n_cmp++;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (cfg_upd === 1'b1) pulses++;
    end
    if (pulses != 0) begin $display("FAIL addr_rej_upd: got %0d want 0", pulses); n_err++; end
    n_cmp++;
    if (cfg2 !== 24'h800000) begin $display("FAIL addr_rej_cfg2: got %h want 800000", cfg2); n_err++; end
    n_cmp++;
    unlock();
    w1f(8'h40); w1f(8'h01);
    @(negedge clk);
    if (cfg1 !== 24'h800000) begin $display("FAIL addr_sid1: got %h want 800000", cfg1); n_err++; end
    n_cmp++;
    w1f(8'h41); w1f(8'h05);
    @(negedge clk);
    if (cfg2 !== 24'hD00000) begin $display("FAIL addr_sid2: got %h want d00000", cfg2); n_err++; end
    n_cmp++;
    pipe_idle = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    unlock();
    w1f(8'h81); w1f(8'h34);
    for (int i = 0; i < 7; i++) tick();
    if (seq_open !== 1'b1) begin $display("FAIL to_7ticks: got %b want 1", seq_open); n_err++; end
    n_cmp++;
    tick();
    @(negedge clk);
    if (seq_open !== 1'b0) begin $display("FAIL to_8ticks: got %b want 0", seq_open); n_err++; end
    n_cmp++;
    w1f(8'h01);
    if (seq_open !== 1'b0) begin $display("FAIL to_after: got %b want 0", seq_open); n_err++; end
    n_cmp++;
    pipe_idle = 1'b1;
    @(negedge clk);
    if (cfg_upd !== 1'b0 || cfg2 !== 24'h800000) begin
      $display("FAIL to_noapply: upd %b cfg2 %h want 0 / 800000", cfg_upd, cfg2); n_err++;
    end
    n_cmp++;
    pipe_idle = 1'b0;

    // an accepted write restarts the count
    unlock();
    for (int i = 0; i < 5; i++) tick();
    w1f(8'h01);
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    if (seq_open !== 1'b1) begin $display("FAIL to_restart: got %b want 1", seq_open); n_err++; end
    n_cmp++;

    // timeout keeps the staged shadow and pending flag
    w1f(8'h00);
    for (int i = 0; i < 8; i++) tick();
    @(negedge clk);
    if (seq_open !== 1'b0) begin $display("FAIL to_keep_open: got %b want 0", seq_open); n_err++; end
    n_cmp++;
    pipe_idle = 1'b1;
    @(negedge clk);
    if (cfg_upd !== 1'b1 || cfg2 !== 24'h000000) begin
      $display("FAIL to_keep_apply: upd %b cfg2 %h want 1 / 000000", cfg_upd, cfg2); n_err++;
    end
    n_cmp++;
    pipe_idle = 1'b0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    do_reset();
    unlock();
    w1f(8'h01); w1f(8'h00);
    w1f(8'h81); w1f(8'h34);
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    if (seq_open !== 1'b0) begin $display("FAIL rmid_open: got %b want 0", seq_open); n_err++; end
    n_cmp++;
    pipe_idle = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (cfg_upd === 1'b1) pulses++;
    end
    pipe_idle = 1'b0;
    if (pulses != 0) begin $display("FAIL rmid_upd: got %0d want 0", pulses); n_err++; end
    n_cmp++;
    if (cfg2 !== 24'h800000) begin $display("FAIL rmid_cfg2: got %h want 800000", cfg2); n_err++; end
    n_cmp++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    unlock();
    w1f(8'h01); w1f(8'h00);
    w1f(8'h01);
    // final data byte completes on the same edge as the apply
    @(negedge clk);
    wr = 1'b1; cs = 2'b01; addr = 5'h1F; data = 8'h01; pipe_idle = 1'b1;
    @(negedge clk);
    wr = 1'b0; cs = 2'b00; addr = 5'h00; data = 8'h00;
    if (cfg_upd !== 1'b1 || cfg2 !== 24'h000000) begin
      $display("FAIL b2b_first: upd %b cfg2 %h want 1 / 000000", cfg_upd, cfg2); n_err++;
    end
    n_cmp++;
    @(negedge clk);
    if (cfg_upd !== 1'b1 || cfg2 !== 24'h800000) begin
      $display("FAIL b2b_second: upd %b cfg2 %h want 1 / 800000", cfg_upd, cfg2); n_err++;
    end
    n_cmp++;
    @(negedge clk);
    if (cfg_upd !== 1'b0) begin $display("FAIL b2b_end: got %b want 0", cfg_upd); n_err++; end
    n_cmp++;
    pipe_idle = 1'b0;
  endtask

  initial begin
    res = 1'b1; tick_ms = 1'b0; wr = 1'b0; cs = 2'b00; addr = 5'h00;
    data = 8'h00; pipe_idle = 1'b0;
    test_reset();
    test_model();
    test_p9_s11();
    test_abort();
    test_addr();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
